// File: rtl/i2c_init_sequencer_pkg.sv
// rtl/i2c_init_sequencer_pkg.sv - shared state, entry widths and entry record for the I2C init sequencer
package i2c_init_sequencer_pkg;

    localparam int REG_W  = 8;
    localparam int DATA_W = 8;
    localparam int DLY_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } seq_state_t;

    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
        logic [DLY_W-1:0]  delay_ticks;
    } init_entry_t;

    function automatic init_entry_t make_entry(input logic [REG_W-1:0]  reg_addr,
                                               input logic [DATA_W-1:0] data,
                                               input logic [DLY_W-1:0]  delay_ticks);
        init_entry_t e;
        e.reg_addr    = reg_addr;
        e.data        = data;
        e.delay_ticks = delay_ticks;
        return e;
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_imu_init_rom.sv
// rtl/i2c_init_sequencer_imu_init_rom.sv - combinational IMU register-write table, index -> entry
module imu_init_rom
    import i2c_init_sequencer_pkg::*;
(
    input  logic [3:0]  index_i,
    output init_entry_t entry_o
);

    // Unpopulated slots read as a harmless write of 00 to register 00 with no delay.
    always_comb begin
        entry_o = make_entry(8'h00, 8'h00, 4'd0);
        case (index_i)
            4'd0:    entry_o = make_entry(8'h6B, 8'h80, 4'd10);
            4'd1:    entry_o = make_entry(8'h6B, 8'h01, 4'd1);
            4'd2:    entry_o = make_entry(8'h1A, 8'h03, 4'd0);
            4'd3:    entry_o = make_entry(8'h1B, 8'h08, 4'd0);
            4'd4:    entry_o = make_entry(8'h1C, 8'h08, 4'd0);
            4'd5:    entry_o = make_entry(8'h19, 8'h04, 4'd0);
            4'd6:    entry_o = make_entry(8'h37, 8'h02, 4'd0);
            4'd7:    entry_o = make_entry(8'h6C, 8'h00, 4'd0);
            default: entry_o = make_entry(8'h00, 8'h00, 4'd0);
        endcase
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// rtl/i2c_init_sequencer.sv - walks the init table through an I2C writer; SEQ_RETRY_EN enables per-entry timeout retries
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter int         NUM_ENTRIES = 8,
    parameter logic [6:0] DEVICE_ADDR = 7'h68,
    parameter int         DELAY_UNIT  = 25000,
    parameter int         ACK_TIMEOUT = 65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        i2c_done,
    output logic        i2c_start,
    output logic [6:0]  i2c_device_address,
    output logic [7:0]  i2c_register_address,
    output logic [7:0]  i2c_data,
    output logic        busy,
    output logic        init_done,
    output logic        error,
    output logic [3:0]  entry_index
);

    localparam int TMO_CW = $clog2(ACK_TIMEOUT + 1);
    localparam int DLY_CW = $clog2(15 * DELAY_UNIT + 1);
    localparam logic [TMO_CW-1:0] TMO_LIMIT  = TMO_CW'(ACK_TIMEOUT);
    localparam logic [DLY_CW-1:0] DLY_UNIT_C = DLY_CW'(DELAY_UNIT);
    localparam logic [3:0]        LAST_IDX   = 4'(NUM_ENTRIES - 1);

    seq_state_t          state_q;
    logic [1:0]          sync_q;
    logic                done_s;
    logic [TMO_CW-1:0]   tmo_q;
    logic [TMO_CW-1:0]   tmo_d;
    logic [DLY_CW-1:0]   dly_q;
    logic [DLY_W-1:0]    ticks_q;
    logic                start_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [3:0]          idx_q;
    logic [REG_W-1:0]    reg_q;
    logic [DATA_W-1:0]   data_q;
    logic                timeout;
    init_entry_t         rom_entry;
`ifdef SEQ_RETRY_EN
    logic [1:0]          retry_q;
`endif

    imu_init_rom u_rom (
        .index_i (idx_q),
        .entry_o (rom_entry)
    );

    // Synchronizer idles high so a writer that is not yet driving looks idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i2c_done};
        end
    end

    assign done_s  = sync_q[1];
    assign tmo_d   = tmo_q + TMO_CW'(1);
    assign timeout = (tmo_d == TMO_LIMIT) &&
                     (((state_q == S_REQ) && done_s) || ((state_q == S_WAIT) && !done_s));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            dly_q   <= '0;
            ticks_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
`ifdef SEQ_RETRY_EN
            retry_q <= '0;
`endif
        end else if (timeout) begin
            // Timeouts only arise in REQ/WAIT, where go is already ignored.
            start_q <= 1'b0;
            tmo_q   <= '0;
`ifdef SEQ_RETRY_EN
            if (retry_q == 2'd3) begin
                state_q <= S_FAIL;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                retry_q <= retry_q + 2'd1;
                state_q <= S_LOAD;
            end
`else
            state_q <= S_FAIL;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (go) begin
                        idx_q   <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
`ifdef SEQ_RETRY_EN
                        retry_q <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    reg_q   <= rom_entry.reg_addr;
                    data_q  <= rom_entry.data;
                    ticks_q <= rom_entry.delay_ticks;
                    start_q <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (!done_s) begin
                        start_q <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_WAIT: begin
                    if (done_s) begin
                        dly_q   <= DLY_CW'(ticks_q) * DLY_UNIT_C;
                        state_q <= S_DELAY;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DELAY: begin
                    if (dly_q == '0) begin
                        state_q <= S_NEXT;
                    end else begin
                        dly_q <= dly_q - DLY_CW'(1);
                    end
                end
                S_NEXT: begin
`ifdef SEQ_RETRY_EN
                    retry_q <= '0;
`endif
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign i2c_start            = start_q;
    assign i2c_device_address   = DEVICE_ADDR;
    assign i2c_register_address = reg_q;
    assign i2c_data             = data_q;
    assign busy                 = busy_q;
    assign init_done            = done_q;
    assign error                = error_q;
    assign entry_index          = idx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb/tb_i2c_init_sequencer.sv - randomized self-checking bench for i2c_init_sequencer with a behavioural writer and table model
module tb_i2c_init_sequencer;

    localparam int DU  = 20;
    localparam int ACK = 400;
    localparam int NE  = 8;
`ifdef SEQ_RETRY_EN
    localparam int MAX_ATT = 4;
`else
    localparam int MAX_ATT = 1;
`endif

    logic       clock;
    logic       reset_n;
    logic       go;
    logic       i2c_done;
    logic       i2c_start;
    logic [6:0] i2c_device_address;
    logic [7:0] i2c_register_address;
    logic [7:0] i2c_data;
    logic       busy;
    logic       init_done;
    logic       error;
    logic [3:0] entry_index;

    i2c_init_sequencer #(
        .NUM_ENTRIES (NE),
        .DEVICE_ADDR (7'h68),
        .DELAY_UNIT  (DU),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .go                   (go),
        .i2c_done             (i2c_done),
        .i2c_start            (i2c_start),
        .i2c_device_address   (i2c_device_address),
        .i2c_register_address (i2c_register_address),
        .i2c_data             (i2c_data),
        .busy                 (busy),
        .init_done            (init_done),
        .error                (error),
        .entry_index          (entry_index)
    );

    // Reference table, written straight from the datasheet-level listing.
    logic [7:0] m_reg  [0:7] = '{8'h6B, 8'h6B, 8'h1A, 8'h1B, 8'h1C, 8'h19, 8'h37, 8'h6C};
    logic [7:0] m_data [0:7] = '{8'h80, 8'h01, 8'h03, 8'h08, 8'h08, 8'h04, 8'h02, 8'h00};
    int         m_dly  [0:7] = '{10, 1, 0, 0, 0, 0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] log_reg[$];
    logic [7:0] log_data[$];
    int         log_start[$];
    int         log_rise[$];
    int         exp_q[$];

    int wr_drop = 3;
    int wr_high = 200;
    bit wr_rand, wr_stuck, wr_active, rst_mid;
    int wr_fail_idx  = 0;
    int wr_fail_left = 0;
    int wr_fail_mode = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Writer model: done drops some cycles after start is seen, rises later, off the clock edges.
    initial begin : writer
        logic [7:0] cap_r, cap_d;
        bit ignore, hang;
        int d, h;
        i2c_done = 1'b1;
        forever begin
            @(posedge clock);
            if (reset_n === 1'b1 && i2c_start === 1'b1) begin
                wr_active = 1;
                cap_r = i2c_register_address;
                cap_d = i2c_data;
                log_reg.push_back(cap_r);
                log_data.push_back(cap_d);
                log_start.push_back(cyc);
                n_checks++;
                if (i2c_device_address !== 7'h68) begin
                    n_fail++;
                    $display("FAIL device_address: got %h, want 68", i2c_device_address);
                end
                ignore = wr_stuck;
                hang   = 0;
                if (!ignore && wr_fail_left > 0 && cap_r == m_reg[wr_fail_idx] && cap_d == m_data[wr_fail_idx]) begin
                    wr_fail_left--;
                    ignore = (wr_fail_mode == 0);
                    hang   = (wr_fail_mode == 1);
                end
                if (ignore) begin
                    for (int k = 0; k < ACK + 20 && i2c_start === 1'b1; k++) @(posedge clock);
                    log_rise.push_back(-1);
                end else begin
                    d = wr_rand ? int'($urandom_range(1, 6)) : wr_drop;
                    h = hang ? ACK + 50 : (wr_rand ? int'($urandom_range(20, 300)) : wr_high);
                    repeat (d) @(posedge clock);
                    #($urandom_range(1, 8));
                    i2c_done = 1'b0;
                    repeat (h) @(posedge clock);
                    #($urandom_range(1, 8));
                    i2c_done = 1'b1;
                    log_rise.push_back(cyc);
                    if (!rst_mid && !hang) begin
                        n_checks++;
                        if (i2c_register_address !== cap_r || i2c_data !== cap_d) begin
                            n_fail++;
                            $display("FAIL field_stability: got %h/%h, want %h/%h",
                                     i2c_register_address, i2c_data, cap_r, cap_d);
                        end
                    end
                end
                wr_active = 0;
            end
        end
    end

    // Expected order of attempted entries given a writer that refuses entry fidx 'fails' times.
    function automatic bit build_expected(input int fidx, input int fails);
        exp_q.delete();
        for (int e = 0; e < NE; e++) begin
            int att;
            att = (e == fidx) ? fails + 1 : 1;
            if (att > MAX_ATT) begin
                repeat (MAX_ATT) exp_q.push_back(e);
                return 1'b1;
            end
            repeat (att) exp_q.push_back(e);
        end
        return 1'b0;
    endfunction

    task automatic clear_log();
        log_reg.delete();
        log_data.delete();
        log_start.delete();
        log_rise.delete();
    endtask

    task automatic pulse_go();
        @(negedge clock);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic wait_writer_idle();
        for (int k = 0; k < 2000 && wr_active; k++) @(negedge clock);
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (init_done === 1'b1 || error === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++;
        if ({i2c_start, busy, init_done, error, entry_index, i2c_register_address, i2c_data} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b busy=%b done=%b err=%b idx=%0d reg=%h data=%h, want all 0",
                     i2c_start, busy, init_done, error, entry_index, i2c_register_address, i2c_data);
        end
        n_checks++;
        if (i2c_device_address !== 7'h68) begin
            n_fail++;
            $display("FAIL reset_device_address: got %h, want 68", i2c_device_address);
        end
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        n_checks++;
        if (i2c_start !== 1'b0 || busy !== 1'b0 || log_reg.size() != 0) begin
            n_fail++;
            $display("FAIL idle_without_go: got start=%b busy=%b txns=%0d, want 0 0 0",
                     i2c_start, busy, log_reg.size());
        end
    endtask

    task automatic test_nominal();
        bit ok, ab;
        wr_rand = 0;
        ab = build_expected(-1, 0);
        clear_log();
        pulse_go();
        n_checks++;
        if (busy !== 1'b1 || init_done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_busy: got busy=%b done=%b err=%b, want 1 0 0", busy, init_done, error);
        end
        wait_end(6000, ok);
        n_checks++;
        if (!ok || init_done !== 1'b1 || error !== ab || busy !== 1'b0 || i2c_start !== 1'b0 || entry_index !== 4'(NE - 1)) begin
            n_fail++;
            $display("FAIL nominal_end: got ok=%b done=%b err=%b busy=%b start=%b idx=%0d, want 1 1 0 0 0 %0d",
                     ok, init_done, error, busy, i2c_start, entry_index, NE - 1);
        end
        n_checks++;
        if (log_reg.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d transactions, want %0d", log_reg.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_reg.size(); i++) begin
            n_checks++;
            if (log_reg[i] !== m_reg[exp_q[i]] || log_data[i] !== m_data[exp_q[i]]) begin
                n_fail++;
                $display("FAIL nominal_txn%0d: got %h/%h, want %h/%h", i, log_reg[i], log_data[i],
                         m_reg[exp_q[i]], m_data[exp_q[i]]);
            end
        end
        for (int i = 1; i < log_start.size() && i < log_rise.size() + 1 && i < NE; i++) begin
            int gap, lo;
            gap = log_start[i] - log_rise[i-1];
            lo  = m_dly[i-1] * DU;
            n_checks++;
            if (gap < lo || gap > lo + 12) begin
                n_fail++;
                $display("FAIL delay_gap%0d: got %0d cycles, want %0d..%0d", i, gap, lo, lo + 12);
            end
        end
        wait_writer_idle();
    endtask

    task automatic test_stray_go();
        bit ok, ab;
        int strays;
        wr_rand = 1;
        ab = build_expected(-1, 0);
        for (int run = 0; run < 2; run++) begin
            clear_log();
            strays = 0;
            pulse_go();
            ok = 1'b0;
            for (int k = 0; k < 8000; k++) begin
                @(negedge clock);
                if (init_done === 1'b1 || error === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                go = (busy === 1'b1) && ($urandom_range(0, 59) == 0 || k == 30);
                if (go) strays++;
            end
            go = 1'b0;
            n_checks++;
            if (!ok || init_done !== 1'b1 || error !== ab || log_reg.size() != exp_q.size() || strays == 0) begin
                n_fail++;
                $display("FAIL stray_go_run%0d: got ok=%b done=%b err=%b txns=%0d strays=%0d, want 1 1 0 %0d >0",
                         run, ok, init_done, error, log_reg.size(), strays, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < log_reg.size(); i++) begin
                n_checks++;
                if (log_reg[i] !== m_reg[exp_q[i]] || log_data[i] !== m_data[exp_q[i]]) begin
                    n_fail++;
                    $display("FAIL stray_go_txn%0d: got %h/%h, want %h/%h", i, log_reg[i], log_data[i],
                             m_reg[exp_q[i]], m_data[exp_q[i]]);
                end
            end
            wait_writer_idle();
        end
        wr_rand = 0;
    endtask

    task automatic test_reset_mid_run();
        bit ok, seen, ab;
        wr_rand = 0;
        clear_log();
        pulse_go();
        seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clock);
            if (log_reg.size() == 5 && i2c_done === 1'b0 && i2c_start === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reach_wait_entry4: got txns=%0d, want WAIT of entry 4", log_reg.size());
        end
        rst_mid = 1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (i2c_start !== 1'b0 || busy !== 1'b0 || entry_index !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got start=%b busy=%b idx=%0d, want 0 0 0", i2c_start, busy, entry_index);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_writer_idle();
        rst_mid = 0;
        ab = build_expected(-1, 0);
        clear_log();
        pulse_go();
        wait_end(6000, ok);
        n_checks++;
        if (!ok || init_done !== 1'b1 || error !== ab || log_reg.size() != exp_q.size() ||
            log_reg.size() == 0 || log_reg[0] !== m_reg[0] || log_data[0] !== m_data[0]) begin
            n_fail++;
            $display("FAIL restart_after_reset: got ok=%b done=%b err=%b txns=%0d first=%h/%h, want 1 1 0 %0d %h/%h",
                     ok, init_done, error, log_reg.size(),
                     (log_reg.size() != 0) ? log_reg[0] : 8'hxx, (log_data.size() != 0) ? log_data[0] : 8'hxx,
                     exp_q.size(), m_reg[0], m_data[0]);
        end
        wait_writer_idle();
    endtask

    task automatic test_stuck_writer();
        bit ok;
        int elapsed;
        wr_stuck = 1;
        clear_log();
        pulse_go();
        wait_end(MAX_ATT * (ACK + 10) + 100, ok);
        elapsed = (log_start.size() != 0) ? cyc - log_start[0] : -1;
        n_checks++;
        if (!ok || error !== 1'b1 || init_done !== 1'b0 || busy !== 1'b0 || i2c_start !== 1'b0 || entry_index !== 4'd0) begin
            n_fail++;
            $display("FAIL stuck_state: got ok=%b err=%b done=%b busy=%b start=%b idx=%0d, want 1 1 0 0 0 0",
                     ok, error, init_done, busy, i2c_start, entry_index);
        end
        n_checks++;
        if (log_reg.size() != MAX_ATT || elapsed < MAX_ATT * ACK || elapsed > MAX_ATT * (ACK + 2) + 4) begin
            n_fail++;
            $display("FAIL stuck_timing: got attempts=%0d elapsed=%0d, want %0d and %0d..%0d",
                     log_reg.size(), elapsed, MAX_ATT, MAX_ATT * ACK, MAX_ATT * (ACK + 2) + 4);
        end
        pulse_go();
        repeat (10) @(negedge clock);
        n_checks++;
        if (i2c_start !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_from_fail: got start=%b busy=%b err=%b, want 1 1 0", i2c_start, busy, error);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (i2c_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_req: got start=%b busy=%b, want 0 0", i2c_start, busy);
        end
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        wr_stuck = 0;
        wait_writer_idle();
    endtask

    task automatic run_fail_case(input string name, input int fails, input int mode);
        bit ok, ab;
        ab = build_expected(2, fails);
        clear_log();
        wr_fail_idx  = 2;
        wr_fail_left = fails;
        wr_fail_mode = mode;
        pulse_go();
        wait_end(12000, ok);
        n_checks++;
        if (!ok || error !== ab || init_done !== !ab || busy !== 1'b0 || i2c_start !== 1'b0 ||
            entry_index !== (ab ? 4'd2 : 4'(NE - 1))) begin
            n_fail++;
            $display("FAIL %s_end: got ok=%b err=%b done=%b busy=%b start=%b idx=%0d, want 1 %b %b 0 0 %0d",
                     name, ok, error, init_done, busy, i2c_start, entry_index, ab, !ab, ab ? 2 : NE - 1);
        end
        n_checks++;
        if (log_reg.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d attempts, want %0d", name, log_reg.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_reg.size(); i++) begin
            n_checks++;
            if (log_reg[i] !== m_reg[exp_q[i]] || log_data[i] !== m_data[exp_q[i]]) begin
                n_fail++;
                $display("FAIL %s_txn%0d: got %h/%h, want %h/%h", name, i, log_reg[i], log_data[i],
                         m_reg[exp_q[i]], m_data[exp_q[i]]);
            end
        end
        wr_fail_left = 0;
        wait_writer_idle();
    endtask

`ifdef SEQ_RETRY_EN
    task automatic test_retry();
        run_fail_case("retry_recover", 2, 0);
        run_fail_case("retry_exhaust", 4, 0);
    endtask
`else
    task automatic test_timeout_fail();
        run_fail_case("req_timeout", 1, 0);
        run_fail_case("wait_timeout", 1, 1);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        go      = 1'b0;
        test_reset();
        test_nominal();
        test_stray_go();
        test_reset_mid_run();
        test_stuck_writer();
`ifdef SEQ_RETRY_EN
        test_retry();
`else
        test_timeout_fail();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of register-write entries in the init table (1..16).
REQ-002 SHALL have parameter DEVICE_ADDR, default 7'h68: 7-bit slave address driven on every transaction.
REQ-003 SHALL have parameter DELAY_UNIT, default 25000: clock cycles per post-write delay tick (1 ms at 25 MHz).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 65535: maximum cycles allowed per handshake phase.
REQ-005 SHALL have port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port go, input, 1: a 1-cycle pulse that starts the init table.
REQ-008 SHALL have port i2c_done, input, 1: the done flag of the I2C writer; it is asynchronous to clock edges.
REQ-009 SHALL have port i2c_start, output, 1: the start request to the writer.
REQ-010 SHALL have port i2c_device_address, output, 7: equal to DEVICE_ADDR.
REQ-011 SHALL have port i2c_register_address, output, 8: the register of the current entry.
REQ-012 SHALL have port i2c_data, output, 8: the data byte of the current entry.
REQ-013 SHALL have ports busy, init_done and error, each output, 1, with these meanings:
- busy: sequence running.
- init_done: table completed.
- error: sequence aborted.
REQ-014 SHALL have port entry_index, output, 4: the current table entry.

Function
REQ-015 SHALL implement these states: IDLE, LOAD, REQ, WAIT, DELAY, NEXT, DONE, FAIL.
REQ-016 SHALL pass i2c_done through a 2-flop synchronizer; all decisions use the synchronized value done_s.
REQ-017 IDLE: on go, SHALL clear entry_index, init_done and error, set busy, and go to LOAD; go is ignored in all other states except DONE and FAIL.
REQ-018 LOAD: SHALL register the entry fields (reg_addr[7:0], data[7:0], delay_ticks[3:0]) from the table into the outputs and go to REQ one cycle later.
REQ-019 REQ: SHALL assert i2c_start and hold it until done_s==0 is seen, then deassert i2c_start and go to WAIT.
REQ-020 WAIT: SHALL go to DELAY when done_s==1 is seen.
REQ-021 i2c_register_address and i2c_data SHALL stay stable from LOAD until WAIT exits.
REQ-022 REQ and WAIT: each SHALL restart a timeout counter on entry; if the counter reaches ACK_TIMEOUT, the block SHALL take the timeout path defined in REQ-034/REQ-035.
REQ-023 DELAY: SHALL wait delay_ticks*DELAY_UNIT cycles; when delay_ticks==0 it SHALL go to NEXT the following cycle.
REQ-024 NEXT: if entry_index==NUM_ENTRIES-1, SHALL go to DONE; otherwise it SHALL increment entry_index and go to LOAD.
REQ-025 DONE: SHALL set init_done=1 and busy=0, and hold until go; go restarts the table as in IDLE.
REQ-026 FAIL: SHALL set error=1, busy=0 and i2c_start=0; entry_index SHALL hold the failing entry; go restarts the table.
REQ-027 If go and a timeout occur in the same cycle, the timeout SHALL win; go in that cycle is dropped.
REQ-028 Counters SHALL be unsigned and sized to hold ACK_TIMEOUT and 15*DELAY_UNIT without overflow; no counter wraps.

Reset
REQ-029 While reset_n==0, the block SHALL asynchronously force state=IDLE and i2c_start=0.
REQ-030 While reset_n==0, the block SHALL also clear busy, init_done, error, entry_index, all counters, i2c_register_address and i2c_data to 0.
REQ-031 Reset asserted mid-transaction SHALL drop i2c_start immediately, with no stop handling; the writer completes or aborts on its own.
REQ-032 The synchronizer flops SHALL reset to 1 (writer idle).

Configuration
REQ-033 The macro SEQ_RETRY_EN SHALL select the timeout behaviour.
REQ-034 With SEQ_RETRY_EN defined, a timeout SHALL return to LOAD for the same entry up to 3 retries, tracked by a 2-bit retry count cleared in NEXT; a 4th timeout on the same entry SHALL go to FAIL.
REQ-035 Without SEQ_RETRY_EN, any timeout SHALL go directly to FAIL, and no retry logic SHALL exist.

Structure
REQ-036 A shared package SHALL hold the state enumeration, the entry field widths (8/8/4) and the entry record typedef.
REQ-037 The table SHALL be a sub-module, imu_init_rom: combinational index[3:0] -> entry.
REQ-038 The default imu_init_rom contents SHALL be:
- 6B<-80 with delay 10
- 6B<-01 with delay 1
- 1A<-03
- 1B<-08
- 1C<-08
- 19<-04
- 37<-02
- 6C<-00

Verification
REQ-039 Nominal run: go, with a writer model that drops done 3 cycles after start and raises it 200 cycles later -> 8 transactions in ROM order, first transaction 6B/80, init_done=1, error=0.
REQ-040 Delay check: entry 0 with delay_ticks=10 and DELAY_UNIT=25000 -> the start of entry 1 comes ≥250000 cycles after done rises for entry 0.
REQ-041 Stuck writer: done held at 1 with SEQ_RETRY_EN undefined -> FAIL after ACK_TIMEOUT, entry_index=0, error=1, i2c_start=0.
REQ-042 Retry: with SEQ_RETRY_EN defined, entry 2 times out twice and then succeeds -> init_done=1; the same entry fails 4 times -> FAIL with entry_index=2.
REQ-043 Reset mid-run: reset_n pulsed low during WAIT of entry 4 -> i2c_start=0 and busy=0 in the same cycle; the next go restarts at entry 0.
REQ-044 Stray go: go pulsed while busy -> ignored, sequence unaffected; go after DONE -> full rerun.
